// File: rtl/sc_io_input_if.sv
// Bundle for the input-conditioning stage in front of the data-memory I/O map.
//
// Signals:
//   sw        raw slide switches (asynchronous)
//   key       raw push-buttons [3:1], active-low (asynchronous)
//   event_clr one-cycle clear strobes [3:1] from the data-memory write decode
//   sw_sync   synchronized switch levels
//   key_level debounced key state [3:1], 1 = pressed
//   key_pulse one-cycle pulse [3:1] per accepted press
//   key_event sticky "pressed since last clear" flags [3:1]
//   io_status packed 32-bit read word
//
// Modports:
//   master  board/memory side: drives the raw inputs and strobes
//   slave   the conditioning stage itself
interface sc_io_input_if;
  logic [9:0]  sw;
  logic [3:1]  key;
  logic [3:1]  event_clr;
  logic [9:0]  sw_sync;
  logic [3:1]  key_level;
  logic [3:1]  key_pulse;
  logic [3:1]  key_event;
  logic [31:0] io_status;

  modport master (
    output sw, key, event_clr,
    input  sw_sync, key_level, key_pulse, key_event, io_status
  );

  modport slave (
    input  sw, key, event_clr,
    output sw_sync, key_level, key_pulse, key_event, io_status
  );
endinterface

// File: rtl/sc_io_input.sv
// sc_io_input: synchronizes board switches and keys, debounces the keys and
// produces clean levels, press pulses, sticky press-event flags and a packed
// status word for the memory-mapped read path.
//
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous, active-high
//   io     sc_io_input_if.slave (sw, key, event_clr in; sw_sync, key_level,
//          key_pulse, key_event, io_status out)
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronized samples needed to accept a key change
//   CNT_W            debounce counter width, must hold DEBOUNCE_CYCLES
//
// Optional feature: define IO_KEY_COUNT_EN to add an 8-bit wrapping press
// counter per key; keys 1 and 2 appear in io_status[31:16], key 3's count is
// reachable only hierarchically as g_key[3].press_count.
module sc_io_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic         clock,
  input  logic         reset,
  sc_io_input_if.slave io
);

  typedef enum logic [1:0] {REL, PCHK, PRS, RCHK} db_state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [9:0]  sw_meta;
  logic [9:0]  sw_sync_q;
  logic [3:1]  key_meta;
  logic [3:1]  key_sync;
  logic [3:1]  pressed;
  logic [3:1]  level_vec;
  logic [3:1]  pulse_vec;
  logic [3:1]  event_q;
  logic [15:0] status_hi;
  logic [31:0] status_q;

  // Two-flop synchronizers. Key flops idle at 1 (released) so a reset never
  // looks like a press.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_meta   <= '0;
      sw_sync_q <= '0;
      key_meta  <= '1;
      key_sync  <= '1;
    end else begin
      sw_meta   <= io.sw;
      sw_sync_q <= sw_meta;
      key_meta  <= io.key;
      key_sync  <= key_meta;
    end
  end

  assign pressed = ~key_sync;

  for (genvar g = 1; g <= 3; g++) begin : g_key
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= REL;
        cnt_q   <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        pulse_q <= pulse_d;
      end
    end

    // The counter only advances while below the limit, so it can never pass
    // DEBOUNCE_CYCLES or wrap.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      pulse_d = 1'b0;
      unique case (state_q)
        REL: begin
          if (pressed[g]) begin
            state_d = PCHK;
            cnt_d   = CNT_ONE;
          end
        end
        PCHK: begin
          if (pressed[g]) begin
            if (cnt_q == CNT_LIMIT) begin
              state_d = PRS;
              cnt_d   = '0;
              level_d = 1'b1;
              pulse_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = REL;
            cnt_d   = '0;
          end
        end
        PRS: begin
          if (!pressed[g]) begin
            state_d = RCHK;
            cnt_d   = CNT_ONE;
          end
        end
        RCHK: begin
          if (!pressed[g]) begin
            if (cnt_q == CNT_LIMIT) begin
              state_d = REL;
              cnt_d   = '0;
              level_d = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = PRS;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = REL;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

`ifdef IO_KEY_COUNT_EN
    logic [7:0] press_count;

    always_ff @(posedge clock) begin
      if (reset) begin
        press_count <= '0;
      end else if (pulse_q) begin
        press_count <= press_count + 8'd1;
      end
    end
`endif

    assign level_vec[g] = level_q;
    assign pulse_vec[g] = pulse_q;
  end

  // Set has priority over clear so a press coinciding with a clear survives.
  always_ff @(posedge clock) begin
    if (reset) begin
      event_q <= '0;
    end else begin
      event_q <= (event_q & ~io.event_clr) | pulse_vec;
    end
  end

`ifdef IO_KEY_COUNT_EN
  assign status_hi = {g_key[2].press_count, g_key[1].press_count};
`else
  assign status_hi = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      status_q <= '0;
    end else begin
      status_q <= {status_hi, sw_sync_q, event_q, level_vec};
    end
  end

  assign io.sw_sync   = sw_sync_q;
  assign io.key_level = level_vec;
  assign io.key_pulse = pulse_vec;
  assign io.key_event = event_q;
  assign io.io_status = status_q;

endmodule

// File: doc/sc_io_input.md
Name: sc_io_input

Overview:
Input-conditioning stage directly upstream of the data-memory I/O port map. It takes raw board switches sw[9:0] and push-buttons key[3:1], which are active-low and bouncing. It synchronizes both, debounces the keys, and produces clean levels, one-cycle press pulses and sticky press-event flags. A packed status word is provided for the memory-mapped read path. The data memory clears event flags with a write strobe, so the CPU can poll key presses without missing or double-counting them.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable synchronized samples needed to accept a key change; legal range 1 to 2^20-1.
CNT_W, 20, width of each per-key debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
clock  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
sw  input  10  raw slide switches, asynchronous to clock.
key  input  3 ([3:1])  raw push-buttons, active-low (0 = pressed), asynchronous.
event_clr  input  3 ([3:1])  one-cycle clear strobes from the data-memory write decode.
sw_sync  output  10  synchronized switch levels.
key_level  output  3 ([3:1])  debounced key state, active-high (1 = pressed).
key_pulse  output  3 ([3:1])  single-cycle pulse on each accepted press.
key_event  output  3 ([3:1])  sticky "pressed since last clear" flags.
io_status  output  32  packed read word for the data memory.

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-high.
- Reset values: sw_sync = 0, key_level = 0, key_pulse = 0, key_event = 0, io_status = 0.
  - Key synchronizer flops reset to 1 (released); switch synchronizer flops reset to 0.
  - All debounce FSMs go to REL and all counters to 0.
  - Reset asserted mid-debounce abandons the check; no pulse is emitted.
- Synchronization: two-flop synchronizer per bit.
  - sw_sync equals raw sw delayed by 2 edges; switches are not debounced.
  - keys are inverted after synchronization, so a raw low becomes "pressed".
- Per-key debounce FSM, with states REL, PCHK, PRS, RCHK:
  - REL: a synchronized pressed sample moves to PCHK with cnt = 1.
  - PCHK, sample still pressed: if cnt == DEBOUNCE_CYCLES, go to PRS, set key_level and pulse key_pulse for 1 cycle; otherwise cnt++.
  - PCHK, sample released: back to REL with cnt = 0 (bounce rejected).
  - PRS: a released sample moves to RCHK with cnt = 1.
  - RCHK, sample still released: if cnt == DEBOUNCE_CYCLES, go to REL and clear key_level; otherwise cnt++.
  - RCHK, sample pressed: back to PRS with cnt = 0.
  - With DEBOUNCE_CYCLES = 1, the transition happens on the first stable sample.
- Latency: a clean raw press held continuously gives key_level = 1 and key_pulse = 1 on edge DEBOUNCE_CYCLES+2 after the first edge that samples it. Release is symmetric; no pulse is generated on release.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES and never wraps.
- Keys are independent: simultaneous presses on several keys each produce their own pulse in the same cycle.
- key_event[i]:
  - set on key_pulse[i]; cleared on event_clr[i]; otherwise holds.
  - If set and clear occur in the same cycle, set wins and the flag stays 1, so no press is lost.
  - Clearing an already-clear flag is a no-op.
- io_status, registered with 1-cycle latency from its sources:
  - [2:0] = key_level[3:1]
  - [5:3] = key_event[3:1]
  - [15:6] = sw_sync
  - [31:16] = 0 (or press counts, see Optional Feature)

Optional Feature:
Macro IO_KEY_COUNT_EN.
- Defined: each key gets an 8-bit saturating-free press counter that increments on key_pulse and wraps 255 -> 0. Counters are reset to 0 by reset.
  - io_status[23:16] = count for key[1]
  - io_status[31:24] = count for key[2]
  - key[3]'s count is internal only and is exposed solely for verification through hierarchy.
- Undefined: no counters exist, and io_status[31:16] = 0.

Test Plan:
- Reset with sw = 10'h2A5 and all keys released -> all outputs 0 during reset; sw_sync = 10'h2A5 exactly 2 edges after reset deasserts.
- DEBOUNCE_CYCLES = 8; hold key[1] = 0 from edge 0 -> key_level[1] = 1 and a single key_pulse[1] at edge 10; key_event[1] = 1 from edge 11; io_status[3] = 1 from edge 12.
- DEBOUNCE_CYCLES = 8; key[2] toggles every 3 cycles for 40 cycles, then stays released -> key_pulse[2] never asserts and key_level[2] stays 0.
- Press key[3] and assert event_clr[3] in the same cycle as key_pulse[3] -> key_event[3] remains 1; one cycle later, event_clr[3] alone -> key_event[3] = 0.
- Assert reset for 1 cycle while key[1] is in PCHK at cnt = 5, keeping key[1] held -> no pulse; the pulse occurs DEBOUNCE_CYCLES+2 edges after reset deasserts.
- With IO_KEY_COUNT_EN defined, 257 clean presses of key[1] -> io_status[23:16] = 8'd1. Without the macro, io_status[31:16] = 16'h0000 throughout.
